// File: rtl/fb_scanout_reader.sv
// -----------------------------------------------------------------------------
// fb_scanout_reader
//
// Purpose:
//   Raster timing generator plus framebuffer reader for a 640x480 style video
//   output. A 256x256 image window, placed at (IMG_X0, IMG_Y0) inside the
//   active area, is fetched from an external synchronous framebuffer and
//   presented on pix_data; everything outside the window is black.
//
//   Pipeline (counter state loaded at edge N shows on the outputs at edge N+2):
//     stage 0 : h/v counters, fb_addr, fb_rd_en and the per-pixel flags are all
//               registered from the *next* counter value, so they share an edge.
//     stage 1 : flags delayed one cycle while the framebuffer returns data.
//     stage 2 : output registers (pix_data, de, hsync, vsync, frame_start).
//   fb_rd_data only reaches an output through the pix_data register.
//
// Ports:
//   clk          in   1   sole clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   en           in   1   scan enable; low parks the raster at (0,0), idle
//   test_pat     in   1   (FB_SCANOUT_TESTPAT_EN only) internal x^y pattern
//   fb_addr      out  16  framebuffer address {img_x, img_y}
//   fb_rd_en     out  1   read strobe, only for in-window pixels
//   fb_rd_data   in   8   pixel byte, valid the cycle after fb_rd_en
//   pix_data     out  8   output pixel, 8'h00 outside window / blanking
//   hsync, vsync out  1   active-low sync
//   de           out  1   data enable for the active area
//   frame_start  out  1   one-cycle pulse with output pixel (0,0)
//
// Optional feature macro: FB_SCANOUT_TESTPAT_EN (adds the test_pat input).
// -----------------------------------------------------------------------------
module fb_scanout_reader #(
    parameter int H_TOTAL      = 800,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int H_SYNC_END   = 752,
    parameter int V_TOTAL      = 525,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490,
    parameter int V_SYNC_END   = 492,
    parameter int IMG_X0       = 192,
    parameter int IMG_Y0       = 112
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
`ifdef FB_SCANOUT_TESTPAT_EN
    input  logic        test_pat,
`endif
    output logic [15:0] fb_addr,
    output logic        fb_rd_en,
    input  logic [7:0]  fb_rd_data,
    output logic [7:0]  pix_data,
    output logic        hsync,
    output logic        vsync,
    output logic        de,
    output logic        frame_start
);

    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

    // All window / sync decoding is done on 32-bit zero-extended copies so that
    // bounds such as IMG_X0+256 never overflow the counter width.
    localparam logic [31:0] X_LO   = 32'(IMG_X0);
    localparam logic [31:0] X_HI   = 32'(IMG_X0 + 256);
    localparam logic [31:0] Y_LO   = 32'(IMG_Y0);
    localparam logic [31:0] Y_HI   = 32'(IMG_Y0 + 256);
    localparam logic [31:0] HA     = 32'(H_ACTIVE);
    localparam logic [31:0] VA     = 32'(V_ACTIVE);
    localparam logic [31:0] HS_LO  = 32'(H_SYNC_START);
    localparam logic [31:0] HS_HI  = 32'(H_SYNC_END);
    localparam logic [31:0] VS_LO  = 32'(V_SYNC_START);
    localparam logic [31:0] VS_HI  = 32'(V_SYNC_END);

    // ---------------- stage 0 state ----------------
    logic [HW-1:0] h_cnt_r;
    logic [VW-1:0] v_cnt_r;
    logic          act_r;      // counters hold a live raster position
    logic          win0_r;
    logic          de0_r;
    logic          hs0_r;      // active-low levels carried through the pipe
    logic          vs0_r;
    logic          fs0_r;

    // ---------------- stage 1 state ----------------
    logic          win1_r;
    logic          de1_r;
    logic          hs1_r;
    logic          vs1_r;
    logic          fs1_r;

`ifdef FB_SCANOUT_TESTPAT_EN
    logic          tp0_r;
    logic          tp1_r;
    logic [7:0]    xor0_r;
    logic [7:0]    xor1_r;
`endif

    // ---------------- combinational ----------------
    logic [HW-1:0] h_nxt_s;
    logic [VW-1:0] v_nxt_s;
    logic [31:0]   h_w_s;
    logic [31:0]   v_w_s;
    logic          in_act_s;
    logic          in_win_s;
    logic          de_s;
    logic          hs_s;
    logic          vs_s;
    logic          fs_s;
    logic          rd_s;
    logic [7:0]    img_x_s;
    logic [7:0]    img_y_s;
    logic [7:0]    pix_nxt_s;

    // Next raster position. While disabled the raster parks at (0,0); the first
    // enabled edge loads (0,0) as a live pixel rather than skipping past it.
    always_comb begin
        h_nxt_s = h_cnt_r;
        v_nxt_s = v_cnt_r;
        if (!en || !act_r) begin
            h_nxt_s = {HW{1'b0}};
            v_nxt_s = {VW{1'b0}};
        end else if (h_cnt_r == H_LAST) begin
            h_nxt_s = {HW{1'b0}};
            if (v_cnt_r == V_LAST) begin
                v_nxt_s = {VW{1'b0}};
            end else begin
                v_nxt_s = v_cnt_r + VW'(1'b1);
            end
        end else begin
            h_nxt_s = h_cnt_r + HW'(1'b1);
            v_nxt_s = v_cnt_r;
        end
    end

    // Decode window, active area and sync for the position about to be loaded.
    always_comb begin
        h_w_s    = 32'(h_nxt_s);
        v_w_s    = 32'(v_nxt_s);
        in_act_s = (h_w_s < HA) && (v_w_s < VA);
        de_s     = en && in_act_s;
        in_win_s = en && in_act_s
                   && (h_w_s >= X_LO) && (h_w_s < X_HI)
                   && (v_w_s >= Y_LO) && (v_w_s < Y_HI);
        hs_s     = !(en && (h_w_s >= HS_LO) && (h_w_s < HS_HI));
        vs_s     = !(en && (v_w_s >= VS_LO) && (v_w_s < VS_HI));
        fs_s     = en && (h_w_s == 32'd0) && (v_w_s == 32'd0);
        // Truncation to 8 bits is intended: the window is exactly 256 wide/high.
        img_x_s  = 8'(h_w_s - X_LO);
        img_y_s  = 8'(v_w_s - Y_LO);
`ifdef FB_SCANOUT_TESTPAT_EN
        // The test pattern is generated internally, so no memory read is issued.
        rd_s     = in_win_s && !test_pat;
`else
        rd_s     = in_win_s;
`endif
    end

    // Stage 0: raster counters, framebuffer request and per-pixel flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_r  <= {HW{1'b0}};
            v_cnt_r  <= {VW{1'b0}};
            act_r    <= 1'b0;
            fb_addr  <= 16'h0000;
            fb_rd_en <= 1'b0;
            win0_r   <= 1'b0;
            de0_r    <= 1'b0;
            hs0_r    <= 1'b1;
            vs0_r    <= 1'b1;
            fs0_r    <= 1'b0;
        end else begin
            h_cnt_r  <= h_nxt_s;
            v_cnt_r  <= v_nxt_s;
            act_r    <= en;
            fb_rd_en <= rd_s;
            // Address holds its last value outside the window.
            if (in_win_s) begin
                fb_addr <= {img_x_s, img_y_s};
            end else begin
                fb_addr <= fb_addr;
            end
            win0_r   <= in_win_s;
            de0_r    <= de_s;
            hs0_r    <= hs_s;
            vs0_r    <= vs_s;
            fs0_r    <= fs_s;
        end
    end

    // Stage 1: hold the flags while the framebuffer answers the stage-0 read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win1_r <= 1'b0;
            de1_r  <= 1'b0;
            hs1_r  <= 1'b1;
            vs1_r  <= 1'b1;
            fs1_r  <= 1'b0;
        end else begin
            win1_r <= win0_r;
            de1_r  <= de0_r;
            hs1_r  <= hs0_r;
            vs1_r  <= vs0_r;
            fs1_r  <= fs0_r;
        end
    end

`ifdef FB_SCANOUT_TESTPAT_EN
    // Test-pattern value and select, delayed to line up with the memory data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tp0_r  <= 1'b0;
            tp1_r  <= 1'b0;
            xor0_r <= 8'h00;
            xor1_r <= 8'h00;
        end else begin
            tp0_r  <= in_win_s && test_pat;
            tp1_r  <= tp0_r;
            xor0_r <= img_x_s ^ img_y_s;
            xor1_r <= xor0_r;
        end
    end
`endif

    // Output pixel select: window data or black.
    always_comb begin
        pix_nxt_s = 8'h00;
`ifdef FB_SCANOUT_TESTPAT_EN
        if (tp1_r) begin
            pix_nxt_s = xor1_r;
        end else if (win1_r) begin
            pix_nxt_s = fb_rd_data;
        end else begin
            pix_nxt_s = 8'h00;
        end
`else
        if (win1_r) begin
            pix_nxt_s = fb_rd_data;
        end else begin
            pix_nxt_s = 8'h00;
        end
`endif
    end

    // Stage 2: output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_data    <= 8'h00;
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            pix_data    <= pix_nxt_s;
            de          <= de1_r;
            hsync       <= hs1_r;
            vsync       <= vs1_r;
            frame_start <= fs1_r;
        end
    end

endmodule
